// File: rtl/core_pkg.sv
// Shared constants for the pipelined RISC-V core.
// Every pipeline stage imports these.
package core_pkg;

  localparam int          DEFAULT_ADDR_W   = 32;
  localparam int          DEFAULT_INST_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

  // addi x0,x0,0 -- the bubble that downstream stages insert after a flush
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry skid buffer that holds fetched {pc, inst} pairs until the IF/ID register takes them.
// The output reads zero when the buffer is empty. 'clear' flushes every entry.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic         rdptr;
  logic         wrptr;

  assign dout = (count != 2'd0) ? mem[rdptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdptr <= 1'b0;
      wrptr <= 1'b0;
      count <= 2'd0;
    end else if (clear) begin
      rdptr <= 1'b0;
      wrptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wrptr] <= din;
        wrptr      <= ~wrptr;
      end
      if (pop)
        rdptr <= ~rdptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle instruction memory,
// and buffers the returned words for the IF/ID register. EX redirects flush all pending work.
module fetch_stage
  import core_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INST_W   = DEFAULT_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready
);

  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        inflight_pc;
  logic                     inflight;
  logic [1:0]               count;
  logic [1:0]               credit;
  logic                     pop;
  logic                     push;
  logic [ADDR_W+INST_W-1:0] head;

  // Buffered plus outstanding reads never exceed two, so the FIFO cannot overflow.
  assign credit   = count + {1'b0, inflight};
  assign if_valid = (count != 2'd0) & ~redirect_valid;
  assign pop      = if_valid & id_ready;
  assign push     = inflight & ~redirect_valid;

  // Held low during reset so no read is issued before the first cycle after release.
  assign imem_en   = ~rst & ~redirect_valid &
                     ((credit < 2'd2) | ((credit == 2'd2) & pop));
  assign imem_addr = pc;

  assign if_pc   = head[ADDR_W+INST_W-1:INST_W];
  assign if_inst = head[INST_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en)
        inflight_pc <= pc;
      if (redirect_valid)
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (imem_en)
        pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  fetch_fifo #(
    .W     (ADDR_W + INST_W),
    .DEPTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({inflight_pc, imem_rdata}),
    .dout  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage. The reference model is the ideal instruction stream:
// consecutive word addresses from each restart point. A second instance covers the PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b1;

  logic        imem_en2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2 = '0;
  logic        if_valid2;
  logic [31:0] if_pc2;
  logic [31:0] if_inst2;

  int          compared = 0;
  int          mismatched = 0;

  logic [31:0] expPc [$];
  logic [31:0] genPc = '0;
  logic [31:0] restartPc = '0;
  int          sinceRestart = 0;
  logic        waitFirst = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
  );

  fetch_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst(rst), .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(if_valid2), .if_pc(if_pc2), .if_inst(if_inst2), .id_ready(1'b1)
  );

  // Memory content is a fixed scramble of the address, distinct from the address itself.
  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= instOf(imem_addr);
    if (imem_en2) imem_rdata2 <= instOf(imem_addr2);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic topUp();
    while (expPc.size() < 4) begin
      expPc.push_back(genPc);
      genPc += 32'd4;
    end
  endtask

  task automatic applyStimulus(input logic rdv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    if (rdv) begin
      expPc.delete();
      genPc        = {rpc[31:2], 2'b00};
      restartPc    = genPc;
      sinceRestart = 0;
      waitFirst    = 1'b1;
    end
    topUp();
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    expPc.delete();
    genPc        = 32'h0;
    restartPc    = 32'h0;
    sinceRestart = 1;
    waitFirst    = 1'b1;
    topUp();
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("rst_imem_en", {31'b0, imem_en}, 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_inst", if_inst, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_imem_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
    releaseReset();
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every consumed instruction.
  initial begin
    logic        stallHeld = 1'b0;
    logic [31:0] heldPc = '0;
    logic [31:0] heldInst = '0;
    logic        prevConsumed = 1'b0;
    int          noPopRun = 0;
    logic [31:0] expWrap = 32'hFFFF_FFF8;
    logic        consumed;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stallHeld    = 1'b0;
        prevConsumed = 1'b0;
        noPopRun     = 0;
        expWrap      = 32'hFFFF_FFF8;
      end else begin
        consumed = if_valid & id_ready;
        if (redirect_valid) begin
          checkOutput("redir_imem_en", {31'b0, imem_en}, 32'h0);
          checkOutput("redir_if_valid", {31'b0, if_valid}, 32'h0);
        end
        if (waitFirst) begin
          if (sinceRestart == 1) begin
            checkOutput("restart_imem_en", {31'b0, imem_en}, 32'h1);
            checkOutput("restart_imem_addr", imem_addr, restartPc);
          end
          if (if_valid) begin
            checkOutput("first_latency", 32'(sinceRestart), 32'd3);
            waitFirst = 1'b0;
          end else if (sinceRestart > 6) begin
            checkOutput("first_valid_timeout", {31'b0, if_valid}, 32'h1);
            waitFirst = 1'b0;
          end
        end
        if (stallHeld && !redirect_valid) begin
          checkOutput("stall_valid", {31'b0, if_valid}, 32'h1);
          checkOutput("stall_pc", if_pc, heldPc);
          checkOutput("stall_inst", if_inst, heldInst);
        end
        if (prevConsumed && !redirect_valid)
          checkOutput("throughput_valid", {31'b0, if_valid}, 32'h1);
        if (noPopRun >= 2 && !redirect_valid && !consumed)
          checkOutput("full_no_issue", {31'b0, imem_en}, 32'h0);
        if (consumed) begin
          if (expPc.size() == 0) begin
            checkOutput("scoreboard_empty", if_pc, 32'hDEAD_BEEF);
          end else begin
            e = expPc.pop_front();
            checkOutput("stream_pc", if_pc, e);
            checkOutput("stream_inst", if_inst, instOf(e));
          end
        end
        if (if_valid2) begin
          checkOutput("wrap_pc", if_pc2, expWrap);
          checkOutput("wrap_inst", if_inst2, instOf(expWrap));
          expWrap += 32'd4;
        end
        stallHeld    = if_valid & ~id_ready & ~redirect_valid;
        heldPc       = if_pc;
        heldInst     = if_inst;
        prevConsumed = consumed;
        noPopRun     = (redirect_valid || consumed) ? 0 : noPopRun + 1;
        sinceRestart = sinceRestart + 1;
      end
    end
  end

  initial begin
    logic [31:0] r;
    $display("[TB] start");
    releaseReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++)  applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++)  applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 6; i++)  applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0103, 1'b1);
    for (int i = 0; i < 6; i++)  applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0040, 1'b1);
    applyStimulus(1'b1, 32'h0000_0080, 1'b1);
    for (int i = 0; i < 6; i++)  applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++)  applyStimulus(1'b0, 32'h0, 1'b0);
    asyncReset();
    for (int i = 0; i < 6; i++)  applyStimulus(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      r = 32'($urandom_range(0, 199));
      if (r < 1)
        asyncReset();
      else if (r < 12)
        applyStimulus(1'b1, $urandom & 32'h0000_FFFF, ($urandom_range(0, 3) != 0));
      else
        applyStimulus(1'b0, 32'h0, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
